// File: rtl/instr_fetch_queue.sv
// Fetch stage: one imem read per accepted PC, {pc, instr} buffered in a DEPTH-entry FIFO for decode.
// Latency: PC accept -> if_valid >= 3 cycles; one read outstanding; flush drops queued and in-flight data.
// Backpressure: pc_ready low while a fetch is outstanding, a dropped response is pending, or the FIFO is full. Optional MISALIGN_CHECK_EN.
module instr_fetch_queue #(
    parameter int INST_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic                  pc_valid,
    output logic                  pc_ready,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic                  imem_rvalid,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    input  logic                  flush,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic [INST_WIDTH-1:0] if_instr
`ifdef MISALIGN_CHECK_EN
    ,
    output logic                  if_misalign
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [INST_WIDTH-1:0] NOP_INSTR = INST_WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t                state_q, state_d;
    logic                  drop_q, drop_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  accept, push, pop;
    logic [ADDR_WIDTH-1:0] push_pc;
    logic [INST_WIDTH-1:0] push_instr;

    logic [ADDR_WIDTH-1:0] fifo_pc    [DEPTH];
    logic [INST_WIDTH-1:0] fifo_instr [DEPTH];
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [CW-1:0]         count_q;

`ifdef MISALIGN_CHECK_EN
    logic misaligned;
    logic push_mis;
    logic fifo_mis [DEPTH];
    assign misaligned = |pc_in[1:0];
`endif

    // drop_q covers a flushed read still in flight; its response must drain before a new PC.
    assign pc_ready = !reset && (state_q == S_IDLE) && !flush && !drop_q && (count_q < FULL_CNT);
    assign accept   = pc_valid && pc_ready;
    assign pop      = if_valid && if_ready && !flush;

    always_comb begin
        state_d    = state_q;
        drop_d     = drop_q;
        push       = 1'b0;
        push_pc    = fetch_pc_q;
        push_instr = imem_rdata;
`ifdef MISALIGN_CHECK_EN
        push_mis   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
`ifdef MISALIGN_CHECK_EN
                    if (misaligned) begin
                        push       = 1'b1;
                        push_pc    = pc_in;
                        push_instr = NOP_INSTR;
                        push_mis   = 1'b1;
                    end else begin
                        state_d = S_REQ;
                    end
`else
                    state_d = S_REQ;
`endif
                end
            end
            S_REQ: begin
                if (flush) drop_d = 1'b1;
                if (imem_ack) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    push    = !drop_q && !flush;
                    drop_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                drop_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            drop_q     <= 1'b0;
            addr_q     <= '0;
            fetch_pc_q <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            if (accept && (state_d == S_REQ)) begin
                addr_q     <= {pc_in[ADDR_WIDTH-1:2], 2'b00};
                fetch_pc_q <= pc_in;
            end
        end
    end

    assign imem_req  = (state_q == S_REQ);
    assign imem_addr = addr_q;

    // A slot is guaranteed at accept time, so push never sees a full FIFO and never meets flush.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= push_pc;
            fifo_instr[wr_ptr] <= push_instr;
`ifdef MISALIGN_CHECK_EN
            fifo_mis[wr_ptr]   <= push_mis;
`endif
        end
    end

    assign if_valid = (count_q != '0);
    assign if_pc    = if_valid ? fifo_pc[rd_ptr] : '0;
    assign if_instr = if_valid ? fifo_instr[rd_ptr] : '0;
`ifdef MISALIGN_CHECK_EN
    assign if_misalign = if_valid ? fifo_mis[rd_ptr] : 1'b0;
`endif

endmodule
